// File: rtl/jigl_pkg.sv
// Shared constants and types for the 65816 glue-logic wait-state generator.
// Holds the CFG field layout, the wait-count width and the FSM state type.
package jigl_pkg;

    localparam int WS_W         = 2;
    localparam int CFG_ROM_LSB  = 0;
    localparam int CFG_RAM_LSB  = 2;
    localparam int CFG_IO12_LSB = 4;
    localparam int CFG_IO34_LSB = 6;

    // ROM=3, RAM=0, IO1/2=3, IO3/4=3 wait states out of reset
    localparam logic [7:0] DEFAULT_CFG = 8'hF3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [WS_W-1:0] ws_max(input logic [WS_W-1:0] a,
                                               input logic [WS_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jigl_waitgen_if.sv
// CPU/decoder-side bus seen by the wait-state generator.
// master = CPU and decoder side, slave = jigl_waitgen.
interface jigl_waitgen_if;
    logic       VDA;
    logic       VPA;
    logic       nRW;
    logic       nWSEN;
    logic       nROMCS;
    logic       nRAM1CS;
    logic       nRAM2CS;
    logic       nIO1SEL;
    logic       nIO2SEL;
    logic       nIO3SEL;
    logic       nIO4SEL;
    logic       nCFGSEL;
    logic [7:0] D;
    logic       RDY;
    logic       WAITING;
    logic [7:0] CFG;

    modport master (
        output VDA, VPA, nRW, nWSEN,
        output nROMCS, nRAM1CS, nRAM2CS,
        output nIO1SEL, nIO2SEL, nIO3SEL, nIO4SEL, nCFGSEL,
        output D,
        input  RDY, WAITING, CFG
    );

    modport slave (
        input  VDA, VPA, nRW, nWSEN,
        input  nROMCS, nRAM1CS, nRAM2CS,
        input  nIO1SEL, nIO2SEL, nIO3SEL, nIO4SEL, nCFGSEL,
        input  D,
        output RDY, WAITING, CFG
    );
endinterface

// File: rtl/jigl_wait_fsm.sv
// IDLE/WAIT state register with a down-counter that holds RDY low for n PHI2 cycles.
// Latency: RDY falls at the posedge opening the access, rises n posedges later.
// Backpressure: nWSEN high aborts a stretch at the next posedge; no input-to-RDY comb path.
module jigl_wait_fsm
    import jigl_pkg::*;
(
    input  logic            PHI2,
    input  logic            nRESET,
    input  logic [WS_W-1:0] n,
    input  logic            start_qual,
    input  logic            nWSEN,
    output logic            RDY,
    output logic            WAITING
);

    state_t          state;
    logic [WS_W-1:0] cnt;

    always_ff @(posedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            RDY     <= 1'b1;
            WAITING <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // n is only sampled here, so a held access is never re-decoded
                    if (!nWSEN && start_qual && (n != '0)) begin
                        state   <= WAIT;
                        cnt     <= n - 2'd1;
                        RDY     <= 1'b0;
                        WAITING <= 1'b1;
                    end else begin
                        RDY     <= 1'b1;
                        WAITING <= 1'b0;
                    end
                end
                WAIT: begin
                    if (nWSEN || (cnt == '0)) begin
                        state   <= IDLE;
                        RDY     <= 1'b1;
                        WAITING <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    RDY     <= 1'b1;
                    WAITING <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jigl_waitgen.sv
// Wait-state generator: decodes selects against CFG and stretches 65816 cycles via RDY.
// Latency: RDY low for n PHI2 cycles from the posedge opening the access (n = max selected field).
// Backpressure: none accepted; CFG writes land on negedge PHI2 only while RDY is high.
module jigl_waitgen
    import jigl_pkg::*;
(
    input  logic          PHI2,
    input  logic          nRESET,
    jigl_waitgen_if.slave bus
);

    logic [7:0]      cfg_q;
    logic [WS_W-1:0] ws_rom;
    logic [WS_W-1:0] ws_ram;
    logic [WS_W-1:0] ws_io12;
    logic [WS_W-1:0] ws_io34;
    logic [WS_W-1:0] n;
    logic            start_qual;
    logic            rdy;
    logic            waiting;

    // Unselected regions contribute 0, so the max picks the slowest selected device
    always_comb begin
        ws_rom  = !bus.nROMCS ? cfg_q[CFG_ROM_LSB +: WS_W] : '0;
        ws_ram  = (!bus.nRAM1CS || !bus.nRAM2CS) ? cfg_q[CFG_RAM_LSB +: WS_W] : '0;
        ws_io12 = (!bus.nIO1SEL || !bus.nIO2SEL) ? cfg_q[CFG_IO12_LSB +: WS_W] : '0;
        ws_io34 = (!bus.nIO3SEL || !bus.nIO4SEL) ? cfg_q[CFG_IO34_LSB +: WS_W] : '0;
        n       = ws_max(ws_max(ws_rom, ws_ram), ws_max(ws_io12, ws_io34));
    end

    assign start_qual = bus.VDA || bus.VPA;

    jigl_wait_fsm u_fsm (
        .PHI2       (PHI2),
        .nRESET     (nRESET),
        .n          (n),
        .start_qual (start_qual),
        .nWSEN      (bus.nWSEN),
        .RDY        (rdy),
        .WAITING    (waiting)
    );

    // Write data is valid late in the cycle, hence the falling-edge capture
    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            cfg_q <= DEFAULT_CFG;
        end else if (!bus.nCFGSEL && !bus.nRW && rdy) begin
            cfg_q <= bus.D;
        end
    end

    assign bus.RDY     = rdy;
    assign bus.WAITING = waiting;
    assign bus.CFG     = cfg_q;

endmodule

// File: tb/tb_jigl_waitgen.sv
// Directed bench for jigl_waitgen: vector table of CFG/select/expected-wait records
// plus hand sequences for reset, ignored writes, nWSEN abort and mid-access reset.
module tb_jigl_waitgen;

    logic PHI2;
    logic nRESET;
    int   n_cmp;
    int   n_fail;

    jigl_waitgen_if bus ();

    jigl_waitgen dut (
        .PHI2   (PHI2),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial PHI2 = 1'b0;
    always #5 PHI2 = ~PHI2;

    // sel bits: [0]ROM [1]RAM1 [2]RAM2 [3]IO1 [4]IO2 [5]IO3 [6]IO4 [7]CFG
    typedef struct {
        logic [7:0] cfg;
        logic [7:0] sel;
        logic       vda;
        logic       vpa;
        logic       nwsen;
        int         exp_waits;
    } vec_t;

    vec_t tv[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PHI2);
        #1;
    endtask

    task automatic bus_idle();
        bus.VDA     = 1'b0;
        bus.VPA     = 1'b0;
        bus.nRW     = 1'b1;
        bus.nWSEN   = 1'b0;
        bus.nROMCS  = 1'b1;
        bus.nRAM1CS = 1'b1;
        bus.nRAM2CS = 1'b1;
        bus.nIO1SEL = 1'b1;
        bus.nIO2SEL = 1'b1;
        bus.nIO3SEL = 1'b1;
        bus.nIO4SEL = 1'b1;
        bus.nCFGSEL = 1'b1;
        bus.D       = 8'h00;
    endtask

    task automatic apply_sel(input logic [7:0] sel);
        bus.nROMCS  = ~sel[0];
        bus.nRAM1CS = ~sel[1];
        bus.nRAM2CS = ~sel[2];
        bus.nIO1SEL = ~sel[3];
        bus.nIO2SEL = ~sel[4];
        bus.nIO3SEL = ~sel[5];
        bus.nIO4SEL = ~sel[6];
        bus.nCFGSEL = ~sel[7];
    endtask

    task automatic write_cfg(input logic [7:0] v);
        bus.D       = v;
        bus.nCFGSEL = 1'b0;
        bus.nRW     = 1'b0;
        step();
        bus_idle();
        check("cfg_write", {24'h0, bus.CFG}, {24'h0, v});
    endtask

    // Holds the access while RDY is low, counting stretched cycles; bounded at 8.
    task automatic access(input logic [7:0] sel, input logic vda, input logic vpa,
                          input logic nwsen, output int waits, output int wt);
        apply_sel(sel);
        bus.VDA   = vda;
        bus.VPA   = vpa;
        bus.nWSEN = nwsen;
        waits = 0;
        wt    = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.WAITING === 1'b1) wt++;
            if (bus.RDY === 1'b1) break;
            waits++;
        end
        bus_idle();
    endtask

    initial begin
        int waits;
        int wt;
        n_cmp  = 0;
        n_fail = 0;

        tv[0]  = '{8'hF3, 8'b0000_0001, 1'b1, 1'b0, 1'b0, 3}; // ROM default
        tv[1]  = '{8'hF3, 8'b0000_0010, 1'b1, 1'b0, 1'b0, 0}; // RAM1 default
        tv[2]  = '{8'h1B, 8'b0000_1000, 1'b1, 1'b0, 1'b0, 1}; // IO1
        tv[3]  = '{8'h1B, 8'b0000_0100, 1'b1, 1'b0, 1'b0, 2}; // RAM2
        tv[4]  = '{8'h1B, 8'b0000_0001, 1'b1, 1'b0, 1'b0, 3}; // ROM
        tv[5]  = '{8'h1B, 8'b0100_0000, 1'b1, 1'b0, 1'b0, 0}; // IO4
        tv[6]  = '{8'hF3, 8'b0000_0001, 1'b1, 1'b0, 1'b1, 0}; // nWSEN high
        tv[7]  = '{8'hF3, 8'b0000_0001, 1'b0, 1'b0, 1'b0, 0}; // internal op
        tv[8]  = '{8'h41, 8'b0010_0001, 1'b1, 1'b0, 1'b0, 1}; // ROM+IO3, both 1
        tv[9]  = '{8'hC1, 8'b0010_0001, 1'b1, 1'b0, 1'b0, 3}; // ROM+IO3, max 3
        tv[10] = '{8'hF3, 8'b0000_0001, 1'b0, 1'b1, 1'b0, 3}; // VPA only
        tv[11] = '{8'hF3, 8'b1000_0000, 1'b1, 1'b0, 1'b0, 0}; // CFG slot read
        tv[12] = '{8'hF3, 8'b0001_0000, 1'b1, 1'b0, 1'b0, 3}; // IO2
        tv[13] = '{8'hF3, 8'b0000_1010, 1'b1, 1'b0, 1'b0, 3}; // RAM1+IO1
        tv[14] = '{8'h1B, 8'b0000_1010, 1'b1, 1'b0, 1'b0, 2}; // RAM1+IO1 -> RAM
        tv[15] = '{8'h00, 8'b0111_1111, 1'b1, 1'b1, 1'b0, 0}; // all zero fields

        bus_idle();
        nRESET = 1'b1;
        #1 nRESET = 1'b0;
        #2;
        check("reset_rdy", {31'h0, bus.RDY}, 32'h1);
        check("reset_waiting", {31'h0, bus.WAITING}, 32'h0);
        check("reset_cfg", {24'h0, bus.CFG}, 32'hF3);
        #9 nRESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_rdy", {31'h0, bus.RDY}, 32'h1);
        end

        // ROM access cycle by cycle: RDY low on cycles 1-3, high on 4
        apply_sel(8'b0000_0001);
        bus.VDA = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("rom_cycle%0d_rdy", c), {31'h0, bus.RDY}, (c == 4) ? 32'h1 : 32'h0);
        end
        bus_idle();

        for (int i = 0; i < 16; i++) begin
            if (bus.CFG !== tv[i].cfg) write_cfg(tv[i].cfg);
            access(tv[i].sel, tv[i].vda, tv[i].vpa, tv[i].nwsen, waits, wt);
            check($sformatf("vec%0d_waits", i), waits, tv[i].exp_waits);
            check($sformatf("vec%0d_waiting", i), wt, tv[i].exp_waits);
        end

        // Read cycle on the CFG slot must not write
        write_cfg(8'h1B);
        bus.D       = 8'h55;
        bus.nCFGSEL = 1'b0;
        bus.nRW     = 1'b1;
        step();
        bus_idle();
        step();
        check("cfg_read_no_write", {24'h0, bus.CFG}, 32'h1B);

        // nWSEN rising mid-stretch releases at the next posedge
        apply_sel(8'b0000_0001);
        bus.VDA = 1'b1;
        step();
        check("abort_c1_rdy", {31'h0, bus.RDY}, 32'h0);
        bus.nWSEN = 1'b1;
        step();
        check("abort_rdy", {31'h0, bus.RDY}, 32'h1);
        check("abort_waiting", {31'h0, bus.WAITING}, 32'h0);
        bus_idle();
        step();
        check("post_abort_rdy", {31'h0, bus.RDY}, 32'h1);

        // Reset during cycle 2 of a 3-wait ROM access
        apply_sel(8'b0000_0001);
        bus.VDA = 1'b1;
        step();
        step();
        check("rst_mid_c2_rdy", {31'h0, bus.RDY}, 32'h0);
        #1 nRESET = 1'b0;
        #1;
        check("rst_mid_rdy", {31'h0, bus.RDY}, 32'h1);
        check("rst_mid_waiting", {31'h0, bus.WAITING}, 32'h0);
        bus_idle();
        #1 nRESET = 1'b1;
        step();
        check("rst_mid_cfg", {24'h0, bus.CFG}, 32'hF3);
        check("rst_mid_idle_rdy", {31'h0, bus.RDY}, 32'h1);
        access(8'b0000_0001, 1'b1, 1'b0, 1'b0, waits, wt);
        check("post_reset_rom_waits", waits, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
